// File: rtl/lo_write_ook_pkg.sv
// Shared definitions for the LF write path: TX FSM states, default timing,
// SSP slot geometry and the received slot word layout.
package lo_write_ook_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      MARK  = 2'd2,
      SPACE = 2'd3
   } tx_state_e;

   localparam int unsigned DEF_SSP_DIV    = 12;
   localparam int unsigned DEF_FIFO_DEPTH = 4;
   localparam int unsigned DEF_START_GAP  = 30;
   localparam int unsigned DEF_WRITE_GAP  = 10;
   localparam int unsigned DEF_ZERO_LEN   = 24;
   localparam int unsigned DEF_ONE_LEN    = 56;

   localparam int unsigned SLOT_BITS    = 9;
   localparam int unsigned SLOT_PERIODS = 10;

   localparam int unsigned CAR_W = 8;
   localparam int unsigned LEN_W = 8;
   localparam logic [CAR_W-1:0] DIV_MIN = 8'd16;

   // One SSP receive slot: valid flag followed by the command byte.
   typedef struct packed {
      logic       valid;
      logic [7:0] data;
   } ssp_word_t;

   // Short divisors would starve the FSM of time per carrier half-period.
   function automatic logic [CAR_W-1:0] clamp_div(input logic [CAR_W-1:0] d);
      return (d < DIV_MIN) ? DIV_MIN : d;
   endfunction

endpackage

// File: rtl/lo_write_ook_tx_fifo.sv
// Command-byte FIFO, show-ahead read (dout is the head entry).
// Ports: clk, rst_n, flush (sync clear), push/din, pop/dout, full, empty.
module lo_tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign dout  = mem_q[rd_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1);
         end
         if (do_pop) rd_d = rd_q + AW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lo_write_ook.sv
// LF reader write path: receives command bytes over SSP and gap/pulse-length
// modulates the LF carrier with them.
// Ports: pck0/nrst clock and async reset; divisor carrier half-period - 1;
// write_en block enable; ssp_dout serial data in; ssp_clk/ssp_frame SSP
// timing out; pwr_lo coil drive, pwr_hi tied low; busy; dbg mirrors pwr_lo.
module lo_write_ook
   import lo_write_ook_pkg::*;
#(
   parameter int unsigned SSP_DIV    = DEF_SSP_DIV,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned START_GAP  = DEF_START_GAP,
   parameter int unsigned WRITE_GAP  = DEF_WRITE_GAP,
   parameter int unsigned ZERO_LEN   = DEF_ZERO_LEN,
   parameter int unsigned ONE_LEN    = DEF_ONE_LEN
) (
   input  logic       pck0,
   input  logic       nrst,
   input  logic [7:0] divisor,
   input  logic       write_en,
   input  logic       ssp_dout,
   output logic       ssp_clk,
   output logic       ssp_frame,
   output logic       pwr_lo,
   output logic       pwr_hi,
   output logic       busy,
   output logic       dbg
);
   localparam logic [7:0]       SSP_TOP   = 8'(SSP_DIV - 1);
   localparam logic [3:0]       POS_LAST  = 4'(SLOT_PERIODS - 1);
   localparam logic [3:0]       POS_PUSH  = 4'(SLOT_BITS);
   localparam logic [LEN_W-1:0] START_LEN = LEN_W'(START_GAP);
   localparam logic [LEN_W-1:0] WRITE_LEN = LEN_W'(WRITE_GAP);
   localparam logic [LEN_W-1:0] ZERO_L    = LEN_W'(ZERO_LEN);
   localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(ONE_LEN);

   logic [CAR_W-1:0] car_cnt_q, car_cnt_d, car_lim_q, car_lim_d;
   logic             phase_q, phase_d, tick_c;
   logic [7:0]       ssp_div_q, ssp_div_d;
   logic             sclk_q, sclk_d, frame_q, frame_d;
   logic [3:0]       pos_q, pos_d;
   logic [7:0]       shift_q, shift_d;
   ssp_word_t        rx_word_c;
   logic             push_c, pop_c;
   tx_state_e        state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       byte_q, byte_d;
   logic             gap_c, pwr_q, pwr_d, busy_q, busy_d;
   logic [7:0]       fifo_dout;
   logic             fifo_full, fifo_empty;

   lo_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (pck0),
      .rst_n (nrst),
      .flush (~write_en),
      .push  (push_c),
      .din   (rx_word_c.data),
      .pop   (pop_c),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Carrier: divisor is latched at each wrap; tick marks a rising phase toggle.
   always_comb begin
      car_cnt_d = car_cnt_q;
      car_lim_d = car_lim_q;
      phase_d   = phase_q;
      tick_c    = 1'b0;
      if (!write_en) begin
         car_cnt_d = '0;
         phase_d   = 1'b0;
         car_lim_d = clamp_div(divisor);
      end else if (car_cnt_q == car_lim_q) begin
         car_cnt_d = '0;
         phase_d   = ~phase_q;
         car_lim_d = clamp_div(divisor);
         tick_c    = ~phase_q;
      end else begin
         car_cnt_d = car_cnt_q + 8'd1;
      end
   end

   // SSP slot receiver: pos 0 is the frame-low period, 1..9 carry the bits.
   always_comb begin
      ssp_div_d = ssp_div_q;
      sclk_d    = sclk_q;
      pos_d     = pos_q;
      frame_d   = frame_q;
      shift_d   = shift_q;
      push_c    = 1'b0;
      rx_word_c = '{valid: shift_q[7], data: {shift_q[6:0], ssp_dout}};
      if (!write_en) begin
         ssp_div_d = '0;
         sclk_d    = 1'b0;
         pos_d     = '0;
         frame_d   = 1'b0;
      end else if (ssp_div_q == SSP_TOP) begin
         ssp_div_d = '0;
         sclk_d    = ~sclk_q;
         if (sclk_q) begin
            if (pos_q == POS_LAST) begin
               pos_d   = '0;
               frame_d = 1'b0;
            end else begin
               pos_d = pos_q + 4'd1;
               if (pos_q == '0) frame_d = ~fifo_full;
            end
         end else if (frame_q) begin
            shift_d = {shift_q[6:0], ssp_dout};
            if (pos_q == POS_PUSH) push_c = rx_word_c.valid;
         end
      end else begin
         ssp_div_d = ssp_div_q + 8'd1;
      end
   end

   // TX FSM, advanced once per carrier period.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      byte_d  = byte_q;
      pop_c   = 1'b0;
      if (!write_en) begin
         state_d = IDLE;
         len_d   = '0;
         idx_d   = '0;
         byte_d  = '0;
      end else if (tick_c) begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  state_d = START;
                  len_d   = START_LEN;
               end
            end
            START: begin
               if (len_q <= 8'd1) begin
                  pop_c   = 1'b1;
                  byte_d  = fifo_dout;
                  idx_d   = 3'd7;
                  state_d = MARK;
                  len_d   = fifo_dout[7] ? ONE_L : ZERO_L;
               end else len_d = len_q - 8'd1;
            end
            MARK: begin
               if (len_q <= 8'd1) begin
                  state_d = SPACE;
                  len_d   = WRITE_LEN;
                  if (idx_q != 3'd0) begin
                     idx_d = idx_q - 3'd1;
                  end else if (!fifo_empty) begin
                     pop_c  = 1'b1;
                     byte_d = fifo_dout;
                     idx_d  = 3'd7;
                  end else begin
                     state_d = IDLE;
                     len_d   = '0;
                  end
               end else len_d = len_q - 8'd1;
            end
            SPACE: begin
               if (len_q <= 8'd1) begin
                  state_d = MARK;
                  len_d   = byte_q[idx_q] ? ONE_L : ZERO_L;
               end else len_d = len_q - 8'd1;
            end
            default: state_d = IDLE;
         endcase
      end
      // Gap follows the next state, so it only moves on a period tick.
      gap_c  = (state_d == START) || (state_d == SPACE);
      pwr_d  = write_en & phase_d & ~gap_c;
      // A pop only happens while the next state is busy anyway.
      busy_d = write_en & ((state_d != IDLE) | ~fifo_empty | push_c);
   end

   always_ff @(posedge pck0 or negedge nrst) begin
      if (!nrst) begin
         car_cnt_q <= '0;
         car_lim_q <= DIV_MIN;
         phase_q   <= 1'b0;
         ssp_div_q <= '0;
         sclk_q    <= 1'b0;
         pos_q     <= '0;
         frame_q   <= 1'b0;
         shift_q   <= '0;
         state_q   <= IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         byte_q    <= '0;
         pwr_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         car_cnt_q <= car_cnt_d;
         car_lim_q <= car_lim_d;
         phase_q   <= phase_d;
         ssp_div_q <= ssp_div_d;
         sclk_q    <= sclk_d;
         pos_q     <= pos_d;
         frame_q   <= frame_d;
         shift_q   <= shift_d;
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         byte_q    <= byte_d;
         pwr_q     <= pwr_d;
         busy_q    <= busy_d;
      end
   end

   assign ssp_clk   = sclk_q;
   assign ssp_frame = frame_q;
   assign pwr_lo    = pwr_q;
   assign dbg       = pwr_q;
   assign pwr_hi    = 1'b0;
   assign busy      = busy_q;

endmodule

// File: tb/tb_lo_write_ook.sv
// Bench for lo_write_ook: an ARM model feeds SSP slots, a monitor decodes
// pwr_lo into gap/mark events and checks them against an expected queue.
module tb_lo_write_ook;
   localparam int START_GAP = 3;
   localparam int WRITE_GAP = 2;
   localparam int ZERO_LEN  = 4;
   localparam int ONE_LEN   = 8;

   logic       pck0 = 1'b0;
   logic       nrst;
   logic [7:0] divisor;
   logic       write_en;
   logic       ssp_dout;
   logic       ssp_clk, ssp_frame, pwr_lo, pwr_hi, busy, dbg;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   logic [8:0] arm_q[$];
   logic [7:0] msg [5];
   logic mon_en = 1'b0;

   lo_write_ook #(
      .SSP_DIV(2), .FIFO_DEPTH(4), .START_GAP(START_GAP),
      .WRITE_GAP(WRITE_GAP), .ZERO_LEN(ZERO_LEN), .ONE_LEN(ONE_LEN)
   ) dut (
      .pck0(pck0), .nrst(nrst), .divisor(divisor), .write_en(write_en),
      .ssp_dout(ssp_dout), .ssp_clk(ssp_clk), .ssp_frame(ssp_frame),
      .pwr_lo(pwr_lo), .pwr_hi(pwr_hi), .busy(busy), .dbg(dbg)
   );

   always #5 pck0 = ~pck0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic emit(input int ev);
      if (exp_q.size() == 0) chk("stream_extra", ev, -1);
      else chk("stream", ev, exp_q.pop_front());
   endtask

   // Gap events are 1000+periods, mark events are the period count.
   task automatic send_msg(input int n);
      exp_q.push_back(1000 + START_GAP);
      for (int i = 0; i < n; i++) begin
         arm_q.push_back({1'b1, msg[i]});
         for (int b = 7; b >= 0; b--) begin
            exp_q.push_back(msg[i][b] ? ONE_LEN : ZERO_LEN);
            if (!(i == n - 1 && b == 0)) exp_q.push_back(1000 + WRITE_GAP);
         end
      end
   endtask

   task automatic wait_pwr(input logic lvl, output int n);
      n = 0;
      while (pwr_lo !== lvl && n < 5000) begin
         @(negedge pck0);
         n++;
      end
      if (n >= 5000) chk("pwr_timeout", 0, 1);
   endtask

   task automatic wait_busy(input logic lvl, input int lim, input string nm);
      int n = 0;
      while (busy !== lvl && n < lim) begin
         @(negedge pck0);
         n++;
      end
      chk(nm, int'(busy), int'(lvl));
   endtask

   task automatic align_rise();
      int n;
      wait_pwr(1'b0, n);
      wait_pwr(1'b1, n);
   endtask

   // ARM side: one word per frame, MSB (valid flag) first, changes on falling ssp_clk.
   initial begin
      logic [8:0] w;
      ssp_dout = 1'b0;
      forever begin
         @(posedge ssp_frame);
         w = (arm_q.size() > 0) ? arm_q.pop_front() : 9'h000;
         for (int b = 8; b >= 0; b--) begin
            ssp_dout = w[b];
            if (b > 0) @(negedge ssp_clk);
         end
         @(negedge ssp_clk);
         ssp_dout = 1'b0;
      end
   end

   // Monitor: long low runs are gaps (21 + 42*G cycles); rises between them count mark periods.
   initial begin
      int   low_n = 0, cnt = 0, g;
      logic in_msg = 1'b0, prev_p = 1'b0, prev_b = 1'b0;
      forever begin
         @(negedge pck0);
         if (!mon_en || !write_en) begin
            low_n  = 0;
            cnt    = 0;
            in_msg = 1'b0;
         end else begin
            if (prev_b && !busy && in_msg) begin
               emit(cnt);
               in_msg = 1'b0;
            end
            if (!pwr_lo) low_n++;
            else if (!prev_p) begin
               if (low_n > 30) begin
                  if (in_msg) emit(cnt);
                  g = ((low_n - 21) % 42 == 0) ? 1000 + (low_n - 21) / 42 : 9999;
                  emit(g);
                  in_msg = 1'b1;
                  cnt    = 1;
               end else cnt++;
               low_n = 0;
            end
         end
         prev_p = pwr_lo;
         prev_b = busy;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n, h, l, viol, rises;
      logic pf, pp;
      nrst     = 1'b0;
      write_en = 1'b0;
      divisor  = 8'd20;

      // T1 reset and disabled quiet
      repeat (5) @(negedge pck0);
      chk("rst_outs", int'({pwr_lo, pwr_hi, ssp_clk, ssp_frame, busy, dbg}), 0);
      nrst = 1'b1;
      viol = 0;
      repeat (1000) begin
         @(negedge pck0);
         if (pwr_lo | ssp_clk | ssp_frame | busy) viol++;
      end
      chk("disabled_quiet", viol, 0);

      // T2 idle carrier and SSP framing
      write_en = 1'b1;
      viol = 0;
      repeat (400) begin
         @(negedge pck0);
         if (busy || (dbg !== pwr_lo) || pwr_hi) viol++;
      end
      chk("idle_no_busy", viol, 0);
      align_rise();
      wait_pwr(1'b0, h);
      wait_pwr(1'b1, l);
      chk("idle_high", h, 21);
      chk("idle_low", l, 21);
      n = 0;
      while (ssp_frame !== 1'b0 && n < 200) begin @(negedge pck0); n++; end
      n = 0;
      while (ssp_frame !== 1'b1 && n < 200) begin @(negedge pck0); n++; end
      h = 0;
      while (ssp_frame === 1'b1 && h < 200) begin @(negedge pck0); h++; end
      l = 0;
      while (ssp_frame === 1'b0 && l < 200) begin @(negedge pck0); l++; end
      chk("frame_high", h, 36);
      chk("frame_low", l, 4);

      // T3 single byte, preceded by a slot with valid=0 that must be dropped
      mon_en = 1'b1;
      arm_q.push_back(9'h0FF);
      msg[0] = 8'hA5;
      send_msg(1);
      wait_busy(1'b1, 3000, "t3_busy_rise");
      wait_busy(1'b0, 20000, "t3_busy_fall");
      repeat (50) @(negedge pck0);
      chk("t3_stream_left", exp_q.size(), 0);
      chk("t3_busy_after", int'(busy), 0);

      // T4 back-pressure with five bytes
      msg[0] = 8'h3C; msg[1] = 8'h81; msg[2] = 8'hFF; msg[3] = 8'h00; msg[4] = 8'h5A;
      send_msg(5);
      wait_busy(1'b1, 3000, "t4_busy_rise");
      rises = 0;
      n = 0;
      pf = ssp_frame;
      pp = pwr_lo;
      while (!(pwr_lo && !pp) && n < 1000) begin
         if (ssp_frame && !pf) rises++;
         pf = ssp_frame;
         pp = pwr_lo;
         @(negedge pck0);
         n++;
      end
      if (ssp_frame && !pf) rises++;
      chk("t4_frames_before_pop", rises, 3);
      chk("t4_arm_pending", arm_q.size(), 1);
      wait_busy(1'b0, 20000, "t4_busy_fall");
      repeat (50) @(negedge pck0);
      chk("t4_stream_left", exp_q.size(), 0);
      mon_en = 1'b0;

      // T5 abort during the mark of bit 3
      arm_q.push_back({1'b1, 8'hFF});
      wait_busy(1'b1, 3000, "t5_busy_rise");
      for (int k = 0; k < 35; k++) align_rise();
      repeat (3) @(negedge pck0);
      chk("t5_in_mark", int'(busy), 1);
      write_en = 1'b0;
      repeat (2) @(negedge pck0);
      chk("t5_abort_outs", int'({pwr_lo, busy, ssp_frame, ssp_clk}), 0);
      repeat (100) @(negedge pck0);
      write_en = 1'b1;
      viol = 0;
      repeat (600) begin
         @(negedge pck0);
         if (busy) viol++;
      end
      chk("t5_no_stale", viol, 0);
      align_rise();
      wait_pwr(1'b0, h);
      wait_pwr(1'b1, l);
      chk("t5_period", h + l, 42);

      // T6 divisor clamp and wrap-only update
      divisor = 8'd5;
      align_rise();
      align_rise();
      wait_pwr(1'b0, h);
      wait_pwr(1'b1, l);
      chk("clamp_high", h, 17);
      chk("clamp_period", h + l, 34);
      divisor = 8'd20;
      align_rise();
      align_rise();
      repeat (5) @(negedge pck0);
      divisor = 8'd40;
      wait_pwr(1'b0, h);
      chk("div_old_high", h + 5, 21);
      wait_pwr(1'b1, l);
      chk("div_new_low", l, 41);
      wait_pwr(1'b0, h);
      chk("div_new_high", h, 41);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
